// File: rtl/led_counter_pkg.sv
// led_counter_pkg: button indices and default widths shared by the LED counter slice.
package led_counter_pkg;
    localparam int BTN_UP      = 0;
    localparam int BTN_DOWN    = 1;
    localparam int BTN_LOAD    = 2;
    localparam int BTN_CLEAR   = 3;
    localparam int NUM_BUTTONS = 4;
    localparam int DEF_WIDTH   = 4;
endpackage

// File: rtl/led_counter_if.sv
// led_counter_if: board pins of the LED counter (buttons and switches in, LEDs out).
interface led_counter_if
    import led_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [NUM_BUTTONS-1:0] BUTTONS;
    logic [WIDTH-1:0]       SWITCHES;
    logic [WIDTH-1:0]       LEDS;
    modport master (output BUTTONS, output SWITCHES, input LEDS);
    modport slave  (input BUTTONS, input SWITCHES, output LEDS);
endinterface

// File: rtl/led_counter_button_debounce.sv
// button_debounce: one button: sync -> debounce (LED_COUNTER_DEBOUNCE_EN) -> rising-edge press pulse.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    // pin register ahead of the 2-flop synchronizer, so the synchronized value lands on cycle 2
    logic [2:0] sync_q;
    logic       sync;
    logic       stable;
    logic       stable_d;
    assign sync = sync_q[2];
`ifdef LED_COUNTER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
`else
    assign stable = sync;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            stable_d <= 1'b0;
            press    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], raw};
            stable_d <= stable;
            press    <= stable & ~stable_d;
        end
    end
endmodule

// File: rtl/led_counter.sv
// led_counter: 4-bit up/down/load/clear LED counter driven by debounced buttons (LED_COUNTER_DEBOUNCE_EN).
module led_counter
    import led_counter_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int DEBOUNCE_CYCLES = 1_250_000
) (
    input logic clk,
    input logic rst,
    led_counter_if.slave bus
);
    logic [NUM_BUTTONS-1:0] press;
    logic [WIDTH-1:0]       sw_meta;
    logic [WIDTH-1:0]       sw_sync;
    logic [WIDTH-1:0]       count;
    logic [WIDTH-1:0]       next;
    for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.BUTTONS[b]),
            .press (press[b])
        );
    end
    always_comb begin
        next = press[BTN_CLEAR]                   ? '0 :
               press[BTN_LOAD]                    ? sw_sync :
               press[BTN_UP] && press[BTN_DOWN]   ? count :
               press[BTN_UP]                      ? count + WIDTH'(1) :
               press[BTN_DOWN]                    ? count - WIDTH'(1) : count;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
            count   <= '0;
        end else begin
            sw_meta <= bus.SWITCHES;
            sw_sync <= sw_meta;
            count   <= next;
        end
    end
    assign bus.LEDS = count;
endmodule

// File: tb/tb_led_counter.sv
// tb_led_counter: directed checks of the LED counter in either debounce configuration.
module tb_led_counter;
    import led_counter_pkg::*;
    localparam int D = 4;
`ifdef LED_COUNTER_DEBOUNCE_EN
    localparam int LAT = 4 + D;
`else
    localparam int LAT = 4;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    led_counter_if #(.WIDTH(4)) bus ();
    led_counter #(.WIDTH(4), .DEBOUNCE_CYCLES(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] mask);
        bus.BUTTONS = mask;
        tick(LAT + 4);
        bus.BUTTONS = '0;
        tick(LAT + 4);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if (bus.LEDS !== 4'h0) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: got %h want 0", i, bus.LEDS);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.BUTTONS = 4'(i * 5 + 1);
            tick(1);
            checks++;
            if (bus.LEDS !== 4'h0) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: got %h want 0", i, bus.LEDS);
            end
        end
        bus.BUTTONS = '0;
        tick(2);
        rst = 1'b0;
        tick(LAT + 4);
        checks++;
        if (bus.LEDS !== 4'h0) begin
            failures++;
            $display("FAIL reset_after: got %h want 0", bus.LEDS);
        end
    endtask

    task automatic test_up_clean();
        bus.BUTTONS[BTN_UP] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            checks++;
            if (bus.LEDS !== ((c >= LAT) ? 4'h1 : 4'h0)) begin
                failures++;
                $display("FAIL up_clean cycle %0d: got %h want %h", c, bus.LEDS, (c >= LAT) ? 4'h1 : 4'h0);
            end
        end
        bus.BUTTONS = '0;
        for (int c = 0; c < 15; c++) begin
            tick(1);
            checks++;
            if (bus.LEDS !== 4'h1) begin
                failures++;
                $display("FAIL up_release cycle %0d: got %h want 1", c, bus.LEDS);
            end
        end
    endtask

    task automatic test_bounce();
`ifdef LED_COUNTER_DEBOUNCE_EN
        for (int i = 0; i < 4; i++) begin
            bus.BUTTONS[BTN_UP] = (i % 2 == 0);
            tick(1);
        end
        bus.BUTTONS[BTN_UP] = 1'b1;
        tick(10);
`else
        bus.BUTTONS[BTN_UP] = 1'b1;
        tick(1);
`endif
        bus.BUTTONS = '0;
        tick(20);
        checks++;
        if (bus.LEDS !== 4'h2) begin
            failures++;
            $display("FAIL bounce: got %h want 2", bus.LEDS);
        end
    endtask

    task automatic test_wrap();
        press(4'b1000);
        checks++;
        if (bus.LEDS !== 4'h0) begin
            failures++;
            $display("FAIL clear: got %h want 0", bus.LEDS);
        end
        press(4'b0010);
        checks++;
        if (bus.LEDS !== 4'hF) begin
            failures++;
            $display("FAIL down_wrap: got %h want f", bus.LEDS);
        end
        press(4'b0001);
        checks++;
        if (bus.LEDS !== 4'h0) begin
            failures++;
            $display("FAIL up_wrap: got %h want 0", bus.LEDS);
        end
        press(4'b0010);
        press(4'b0010);
        checks++;
        if (bus.LEDS !== 4'hE) begin
            failures++;
            $display("FAIL down_twice: got %h want e", bus.LEDS);
        end
    endtask

    task automatic test_load();
        bus.SWITCHES = 4'hA;
        tick(3);
        press(4'b0100);
        checks++;
        if (bus.LEDS !== 4'hA) begin
            failures++;
            $display("FAIL load: got %h want a", bus.LEDS);
        end
        press(4'b0011);
        checks++;
        if (bus.LEDS !== 4'hA) begin
            failures++;
            $display("FAIL up_down_same: got %h want a", bus.LEDS);
        end
        press(4'b1100);
        checks++;
        if (bus.LEDS !== 4'h0) begin
            failures++;
            $display("FAIL clear_over_load: got %h want 0", bus.LEDS);
        end
        bus.SWITCHES = 4'h5;
        tick(3);
        press(4'b0110);
        checks++;
        if (bus.LEDS !== 4'h5) begin
            failures++;
            $display("FAIL load_over_down: got %h want 5", bus.LEDS);
        end
    endtask

    task automatic test_reset_priority();
        bus.BUTTONS[BTN_UP] = 1'b1;
        tick(LAT);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if (bus.LEDS !== 4'h0) begin
            failures++;
            $display("FAIL reset_priority: got %h want 0", bus.LEDS);
        end
        tick(LAT);
        checks++;
        if (bus.LEDS !== 4'h0) begin
            failures++;
            $display("FAIL held_early: got %h want 0", bus.LEDS);
        end
        tick(1);
        checks++;
        if (bus.LEDS !== 4'h1) begin
            failures++;
            $display("FAIL held_fresh: got %h want 1", bus.LEDS);
        end
        bus.BUTTONS = '0;
        tick(LAT + 4);
        checks++;
        if (bus.LEDS !== 4'h1) begin
            failures++;
            $display("FAIL held_release: got %h want 1", bus.LEDS);
        end
    endtask

    initial begin
        bus.BUTTONS  = '0;
        bus.SWITCHES = '0;
        test_reset();
        test_up_clean();
        test_bounce();
        test_wrap();
        test_load();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_counter.md
# led_counter

Board-level 4-bit up/down counter driving the LEDs from the push-buttons, with parallel load from the slide switches. It is the output-side companion of the existing switch-to-LED passthrough: raw asynchronous inputs become clean one-cycle events that drive a registered value onto `LEDS`. It sits at the top level, directly between the board pins and the LED pins.

## Interface
- `WIDTH`, 4: counter, switch and LED width.
- `DEBOUNCE_CYCLES`, 1_250_000: consecutive stable cycles required to accept a button change (10 ms at 125 MHz). Must be ≥1.
- `clk`  input  1  board clock, all logic rising-edge.
- `rst`  input  1  synchronous, active-high reset.
- `BUTTONS`  input  4  raw, asynchronous, bouncing buttons: [0] up, [1] down, [2] load, [3] clear.
- `SWITCHES`  input  WIDTH  raw slide switches, sampled on load.
- `LEDS`  output  WIDTH  registered counter value.

## Operation
- Per button: 2-flop synchronizer → debouncer → rising-edge detector → 1-cycle `press` pulse. Releases produce no event.
- Debouncer: `stable` (reset 0) plus a counter. The counter increments each cycle the synchronized input ≠ `stable` and clears whenever they are equal. When the counter reaches `DEBOUNCE_CYCLES`, `stable` takes the synchronized value and the counter clears. A glitch shorter than `DEBOUNCE_CYCLES` cycles is ignored.
- `SWITCHES` pass through their own 2-flop synchronizer. Load captures the synchronized value.
- Counter update on the cycle after the press pulses, priority high→low:
  - clear: count ← 0.
  - load: count ← synchronized `SWITCHES`.
  - up and down both pulsing: no change.
  - up: count ← count+1 mod 2^WIDTH (4'hF → 4'h0).
  - down: count ← count−1 mod 2^WIDTH (4'h0 → 4'hF).
- Holding a button produces exactly one event. Auto-repeat is not supported.
- Reset: synchronizers, `stable`, debounce counters, press pulses and `LEDS` all go to 0. Reset has priority over any event in the same cycle.
- A button held high across reset release is treated as a fresh press and fires once, `DEBOUNCE_CYCLES` stable cycles after the synchronizer sees it.

## Timing
- Call the first `clk` edge that samples a raw button high cycle 0.
  - Synchronizer output changes at cycle 2.
  - `stable` changes at cycle 2+`DEBOUNCE_CYCLES`.
  - Press pulse is high at cycle 3+`DEBOUNCE_CYCLES`.
  - `LEDS` updates at cycle 4+`DEBOUNCE_CYCLES`.
- With debounce compiled out, `LEDS` updates at cycle 4.
- Switch-to-load path: the switch value must be stable for at least 2 cycles before the load pulse.
- No combinational path from any input to `LEDS`.

## Configuration
- `LED_COUNTER_DEBOUNCE_EN` defined: debouncer instantiated as described.
- Undefined: `stable` is the synchronized input directly. No debounce counters are synthesized, and `DEBOUNCE_CYCLES` is ignored. This mode is for fast simulation and for bench drivers that are already clean.

## Structure
- `led_counter_pkg`:
  - button index constants `BTN_UP=0`, `BTN_DOWN=1`, `BTN_LOAD=2`, `BTN_CLEAR=3`;
  - `NUM_BUTTONS=4`;
  - default `WIDTH`.
- Sub-module `button_debounce`: synchronizer + debouncer + edge detector for one bit, with parameter `DEBOUNCE_CYCLES`. It is instantiated `NUM_BUTTONS` times.
- Top level holds the switch synchronizer, the priority logic and the count register.

## Test plan
All cases use `DEBOUNCE_CYCLES=4` with the macro defined unless stated.
- Reset, then 10 idle cycles → `LEDS`=0 throughout. Hold `rst` while toggling buttons → `LEDS` stays 0.
- Clean 20-cycle up press from 0 → `LEDS`=1 exactly at cycle 8, with no further change while held or on release.
- Up bounce of 1-0-1-0 (1-cycle glitches) followed by a steady 10-cycle high → exactly one increment.
- Down at 4'h0 → 4'hF. Up at 4'hF → 4'h0.
- `SWITCHES`=4'hA, then load → `LEDS`=4'hA. Up and down pressed on the same cycle → `LEDS` stays 4'hA. Clear and load pressed together → `LEDS`=0.
- Macro undefined: single clean up press → `LEDS` increments at cycle 4. A 1-cycle glitch → one increment, as expected in this mode.
